// File: rtl/bitserial_alu_sched_pkg.sv
// ============================================================================
// Module : bitserial_alu_sched_pkg
// Desc   : Shared opcodes, FSM state type and default sizes for the scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bitserial_alu_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bitserial_alu_sched_if.sv
// ============================================================================
// Module : bitserial_alu_sched_if
// Desc   : Requester-side bus of the shared bit-serial ALU (requests, result).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface bitserial_alu_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] a;
    logic [WIDTH*NREQ-1:0] b;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [WIDTH-1:0]      result;
    logic                  cout;

    modport master (
        output req, op, a, b,
        input  gnt, busy, done, done_id, result, cout
    );

    modport slave (
        input  req, op, a, b,
        output gnt, busy, done, done_id, result, cout
    );
endinterface

`default_nettype wire

// File: rtl/bitserial_alu_sched_slice.sv
// ============================================================================
// Module : bitserial_slice (+ nand-based AND/XOR cells)
// Desc   : Combinational 1-bit ALU slice for AND/XOR/ADD/SUB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bitserial_nand_and2 (
    input  wire logic a_i,
    input  wire logic b_i,
    output logic      y_o
);
    logic w_n;
    assign w_n = ~(a_i & b_i);
    assign y_o = ~(w_n & w_n);
endmodule

module bitserial_nand_xor2 (
    input  wire logic a_i,
    input  wire logic b_i,
    output logic      y_o
);
    logic w_n1, w_n2, w_n3;
    assign w_n1 = ~(a_i & b_i);
    assign w_n2 = ~(a_i & w_n1);
    assign w_n3 = ~(b_i & w_n1);
    assign y_o  = ~(w_n2 & w_n3);
endmodule

module bitserial_slice (
    input  wire logic       a_i,
    input  wire logic       b_i,
    input  wire logic       cin_i,
    input  wire logic [1:0] op_i,
    output logic            s_o,
    output logic            co_o
);
    logic w_x, w_g, w_cq, w_sum, w_np1, w_np0, w_sel_and, w_diff, w_m, w_cx, w_cs;

    bitserial_nand_xor2 u_x    (.a_i(a_i),       .b_i(b_i),      .y_o(w_x));
    bitserial_nand_and2 u_g    (.a_i(a_i),       .b_i(b_i),      .y_o(w_g));
    bitserial_nand_and2 u_cq   (.a_i(cin_i),     .b_i(op_i[1]),  .y_o(w_cq));
    bitserial_nand_xor2 u_sum  (.a_i(w_x),       .b_i(w_cq),     .y_o(w_sum));
    bitserial_nand_xor2 u_np1  (.a_i(op_i[1]),   .b_i(1'b1),     .y_o(w_np1));
    bitserial_nand_xor2 u_np0  (.a_i(op_i[0]),   .b_i(1'b1),     .y_o(w_np0));
    bitserial_nand_and2 u_sel  (.a_i(w_np1),     .b_i(w_np0),    .y_o(w_sel_and));
    // AND result is selected by XOR-ing in the difference against the sum path.
    bitserial_nand_xor2 u_diff (.a_i(w_g),       .b_i(w_sum),    .y_o(w_diff));
    bitserial_nand_and2 u_m    (.a_i(w_sel_and), .b_i(w_diff),   .y_o(w_m));
    bitserial_nand_xor2 u_s    (.a_i(w_sum),     .b_i(w_m),      .y_o(s_o));
    // ab and cin(a^b) are never both 1, so XOR implements their OR.
    bitserial_nand_and2 u_cx   (.a_i(w_cq),      .b_i(w_x),      .y_o(w_cx));
    bitserial_nand_xor2 u_cs   (.a_i(w_g),       .b_i(w_cx),     .y_o(w_cs));
    bitserial_nand_and2 u_co   (.a_i(op_i[1]),   .b_i(w_cs),     .y_o(co_o));
endmodule

`default_nettype wire

// File: rtl/bitserial_alu_sched.sv
// ============================================================================
// Module : bitserial_alu_sched
// Desc   : Round-robin scheduler sharing one bit-serial ALU slice, LSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bitserial_alu_sched
    import bitserial_alu_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = 2,
    parameter int CNTW  = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    bitserial_alu_sched_if.slave bus_if
);
    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, cur_q, done_id_q, w_win;
    logic             w_found;
    logic [1:0]       op_q, w_sel_op;
    logic [WIDTH-1:0] a_q, b_q, res_q, result_q, w_sel_a, w_sel_b, w_res_next;
    logic             carry_q, cout_q;
    logic [CNTW-1:0]  cnt_q;
    logic             w_s, w_co, w_b_eff, w_last, w_busy, w_done;

    // Rotating search starting just after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && bus_if.req[IDW'((int'(ptr_q) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cur_q == IDW'(i)) begin
                w_sel_op = bus_if.op[2*i +: 2];
                w_sel_a  = bus_if.a[WIDTH*i +: WIDTH];
                w_sel_b  = bus_if.b[WIDTH*i +: WIDTH];
            end
        end
    end

    assign w_last     = (cnt_q == CNTW'(WIDTH - 1));
    assign w_b_eff    = b_q[0] ^ (op_q == OP_SUB);
    assign w_res_next = {w_s, res_q[WIDTH-1:1]};

    bitserial_slice u_slice (
        .a_i   (a_q[0]),
        .b_i   (w_b_eff),
        .cin_i (carry_q),
        .op_i  (op_q),
        .s_o   (w_s),
        .co_o  (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_found) state_d = S_LOAD;
            end
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (w_last) state_d = S_DONE;
            S_DONE: begin
                w_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= IDW'(NREQ - 1);
            cur_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        cur_q <= w_win;
                        ptr_q <= w_win;
                    end
                end
                S_LOAD: begin
                    op_q    <= w_sel_op;
                    a_q     <= w_sel_a;
                    b_q     <= w_sel_b;
                    carry_q <= (w_sel_op == OP_SUB);
                    cnt_q   <= '0;
                end
                S_SHIFT: begin
                    res_q   <= w_res_next;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= op_q[1] & w_co;
                    cnt_q   <= cnt_q + CNTW'(1);
                    // Publish on the last bit so the outputs are valid in DONE.
                    if (w_last) begin
                        result_q  <= w_res_next;
                        cout_q    <= w_co;
                        done_id_q <= cur_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_if.busy    = w_busy;
    assign bus_if.done    = w_done;
    assign bus_if.gnt     = w_busy ? (NREQ'(1) << cur_q) : '0;
    assign bus_if.done_id = done_id_q;
    assign bus_if.result  = result_q;
    assign bus_if.cout    = cout_q;

endmodule

`default_nettype wire

// File: doc/bitserial_alu_sched.md
Name: bitserial_alu_sched

Overview:
Round-robin scheduler that shares one bit-serial ALU slice among NREQ requesters. The slice is built from the team's nand-based AND/XOR gate cells. The block arbitrates requests, captures the winner's operands, and sequences the slice LSB-first for WIDTH cycles. It then returns a WIDTH-bit result with a one-cycle done pulse. It sits between the requesting units and the gate-level datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits (2..32)
IDW, 2, requester index width, equal to ceil(log2(NREQ))
CNTW, 3, bit-counter width, equal to ceil(log2(WIDTH))

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset
req  in  NREQ  per-requester request, level
op  in  2*NREQ  per-requester opcode; requester i uses bits [2i+1:2i]
a  in  WIDTH*NREQ  per-requester operand A, packed the same way
b  in  WIDTH*NREQ  per-requester operand B
gnt  out  NREQ  one-hot grant
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle completion pulse
done_id  out  IDW  index of the requester whose result is being returned
result  out  WIDTH  result word
cout  out  1  carry out (ADD/SUB only)

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: asynchronous, rst_n=0 takes effect immediately.
  - Outputs: gnt=0, busy=0, done=0, done_id=0, result=0, cout=0.
  - Internal: state=IDLE, bit counter=0, carry=0, priority pointer=NREQ-1 (req0 has highest priority after reset).
  - Reset asserted mid-operation aborts the operation; no done is produced.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - If req is nonzero, pick the first asserted req searching from pointer+1 with wrap-around.
  - Set gnt one-hot to the winner, update the pointer to the winner, and go to LOAD.
  - If req is zero, stay in IDLE.
- LOAD (1 cycle):
  - Capture the winner's op, a and b into internal shift registers.
  - Set carry to 1 for SUB, 0 otherwise; clear the bit counter.
  - Go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, feed the slice with a[0], b[0] (b inverted for SUB) and the carry.
  - Shift the slice output into the result shift register at the MSB and shift the operands right.
  - For ADD/SUB, carry takes the slice carry-out. For AND/XOR, carry is forced to 0.
  - Go to DONE when the counter reaches WIDTH-1.
- DONE (1 cycle):
  - done=1. result, cout and done_id are updated this cycle and hold until the next DONE.
  - Then go to IDLE.
- gnt stays asserted from the LOAD cycle through the DONE cycle and is 0 in IDLE.
- Opcodes:
  - 00 AND: a&b
  - 01 XOR: a^b
  - 10 ADD: a+b, cout = carry out of the MSB
  - 11 SUB: a+~b+1, cout=1 means no borrow
  - All arithmetic is modulo 2^WIDTH.
- Latency: a req seen in IDLE cycle t gives done in cycle t+WIDTH+2. Back-to-back service period is WIDTH+3 cycles.
- Requester rules:
  - Hold req, op, a and b stable until gnt is seen.
  - Operands may change after LOAD.
  - Deasserting req during LOAD, SHIFT or DONE does not abort; the operation completes and done still pulses.
  - A req still high in the IDLE cycle after DONE is eligible again, but rotation serves the other pending requesters first.
- A req rising while busy is ignored until IDLE.
- Simultaneous requests are resolved purely by the rotating pointer; no starvation. The worst-case wait is NREQ-1 service periods.

Decomposition:
- Shared package/include:
  - opcode constants OP_AND=2'b00, OP_XOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11
  - state encoding IDLE/LOAD/SHIFT/DONE
  - default NREQ/WIDTH
- Sub-module bitserial_slice:
  - Combinational 1-bit slice with inputs a, b, cin, op and outputs s, co.
  - Built only from the nand-based AND/XOR gate cells.
  - co = ab | cin(a^b) for ADD/SUB, 0 otherwise.
- Arbiter, counter, shift registers and FSM live in bitserial_alu_sched.

Test Plan:
1. req=0001, op0=ADD, a0=0x5A, b0=0x3C (WIDTH=8) -> gnt=0001 the cycle after req; done 10 cycles after req is sampled; result=0x96, cout=0, done_id=0.
2. ADD 0xFF+0x01 -> result=0x00, cout=1. SUB 0x10-0x20 -> result=0xF0, cout=0. SUB 0x20-0x10 -> result=0x10, cout=1.
3. AND 0xF0,0x3C -> result=0x30, cout=0. XOR 0xF0,0x3C -> result=0xCC, cout=0.
4. req=1111 held continuously -> grants in order 0,1,2,3,0; done_id matches each grant; done pulses exactly 11 cycles apart; gnt is never multi-hot.
5. rst_n=0 during the 4th SHIFT cycle -> all outputs 0 in that same cycle with no done. After release, req=0110 -> req1 is granted first.
6. req0 dropped during SHIFT -> done still pulses with the correct result. req=0101 after req0's DONE -> req2 is granted before req0.
